// File: rtl/diff_wb_stage.sv
// Writeback skid buffer for diff-unit results: a 2-entry FIFO feeding the
// register-file write port, plus zero flag, sticky error and retire counter.
module diff_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         in_diff,
  input  logic               in_eq,
  input  logic [RADDR_W-1:0] in_rd,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic               flag_zero,
  output logic               err,
  output logic [CNT_W-1:0]   retired,
  output logic [1:0]         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and in_ready never sees wb_ready.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0]  data;
    logic               eq;
  } entry_t;

  state_t state;
  entry_t head;
  entry_t tail;
  entry_t new_entry;
  logic   push;
  logic   pop;
  logic   in_ok;

  assign in_ready  = !rst && (state != FULL);
  assign wb_valid  = (state != EMPTY);
  assign wb_rd     = wb_valid ? head.rd : '0;
  assign wb_data   = wb_valid ? head.data : '0;
  assign dbg_state = state;

  assign push = in_valid && in_ready;
  assign pop  = wb_valid && wb_ready;

  // eq and diff must agree; anything else is stored as a harmless zero/equal result.
  assign in_ok = (in_eq && (in_diff == 6'd0)) ||
                 (!in_eq && (in_diff != 6'd0) && (in_diff <= 6'd32));

  always_comb begin
    new_entry      = '0;
    new_entry.rd   = in_rd;
    new_entry.data = in_ok ? {{(DATA_W-6){1'b0}}, in_diff} : '0;
    new_entry.eq   = in_ok ? in_eq : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      head      <= '0;
      tail      <= '0;
      flag_zero <= 1'b0;
      err       <= 1'b0;
      retired   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= new_entry;
            state <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail  <= new_entry;
              state <= FULL;
            end
            2'b01: state <= EMPTY;
            2'b11: head <= new_entry;
            default: state <= ONE;
          endcase
        end
        FULL: begin
          if (pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase

      if (pop) begin
        flag_zero <= head.eq;
        if (retired != {CNT_W{1'b1}}) retired <= retired + CNT_W'(1);
      end

      if (push && !in_ok) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_diff_wb_stage.sv
// Bench for diff_wb_stage: a cycle model with an expected-write queue checks
// every output each cycle; a second instance with a 2-bit counter checks saturation.
module tb_diff_wb_stage;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int EW      = RADDR_W + DATA_W + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [5:0]         in_diff = '0;
  logic               in_eq = 1'b0;
  logic [RADDR_W-1:0] in_rd = '0;
  logic               wb_ready = 1'b0;

  logic               in_ready, wb_valid, flag_zero, err;
  logic [RADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]  wb_data;
  logic [15:0]        retired;
  logic [1:0]         dbg_state;

  logic               in_ready2, wb_valid2, flag_zero2, err2;
  logic [RADDR_W-1:0] wb_rd2;
  logic [DATA_W-1:0]  wb_data2;
  logic [1:0]         retired2;
  logic [1:0]         dbg_state2;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;
  bit rand_wb  = 0;

  logic [EW-1:0] exp_q[$];
  logic          m_flag, m_err;
  int            m_cnt, m_cnt2;

  diff_wb_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_diff(in_diff), .in_eq(in_eq), .in_rd(in_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_zero(flag_zero), .err(err), .retired(retired), .dbg_state(dbg_state)
  );

  diff_wb_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_diff(in_diff), .in_eq(in_eq), .in_rd(in_rd),
    .wb_valid(wb_valid2), .wb_ready(wb_ready), .wb_rd(wb_rd2), .wb_data(wb_data2),
    .flag_zero(flag_zero2), .err(err2), .retired(retired2), .dbg_state(dbg_state2)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: model predicts outputs, compares on the falling edge
  always @(negedge clk) begin
    if (started) begin
      logic          e_ready, e_wbv, e_ok, e_push, e_pop;
      logic [EW-1:0] hd, ne;
      e_ready = !rst && (exp_q.size() < 2);
      e_wbv   = (exp_q.size() != 0);
      hd      = e_wbv ? exp_q[0] : '0;
      check("in_ready", 64'(in_ready), 64'(e_ready));
      check("wb_valid", 64'(wb_valid), 64'(e_wbv));
      check("wb_rd", 64'(wb_rd), 64'(hd[EW-1 -: RADDR_W]));
      check("wb_data", 64'(wb_data), 64'(hd[DATA_W:1]));
      check("flag_zero", 64'(flag_zero), 64'(m_flag));
      check("err", 64'(err), 64'(m_err));
      check("retired", 64'(retired), 64'(m_cnt));
      check("retired_sat", 64'(retired2), 64'(m_cnt2));
      if (rst) begin
        exp_q.delete();
        m_flag = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
      end else begin
        e_pop  = e_wbv && wb_ready;
        e_push = in_valid && e_ready;
        if (e_pop) begin
          m_flag = hd[0];
          void'(exp_q.pop_front());
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        if (e_push) begin
          e_ok = (in_eq && in_diff == 0) || (!in_eq && in_diff >= 1 && in_diff <= 32);
          ne = {in_rd, (e_ok ? {26'd0, in_diff} : 32'd0), (e_ok ? in_eq : 1'b1)};
          exp_q.push_back(ne);
          if (!e_ok) m_err = 1;
        end
      end
    end
  end

  // driver tasks
  task automatic send(input logic [RADDR_W-1:0] rd, input logic [5:0] d, input logic e);
    bit ok = 0;
    in_valid = 1; in_rd = rd; in_diff = d; in_eq = e;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    in_diff = $urandom_range(0, 63);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) begin @(posedge clk); #1; end
    rst = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_wb) wb_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    m_flag = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
    in_valid = 1; in_diff = 6'd5; in_rd = 5'd9;
    @(posedge clk); #1;
    started = 1;
    do_reset(2);
    in_valid = 0;
    idle(3);

    // single result
    wb_ready = 1;
    send(5'd7, 6'd5, 1'b0);
    idle(3);

    // back-pressure: two accepted, third waits for a pop
    wb_ready = 0;
    send(5'd1, 6'd32, 1'b0);
    send(5'd2, 6'd0, 1'b1);
    in_valid = 1; in_rd = 5'd3; in_diff = 6'd4; in_eq = 0;
    repeat (3) begin @(posedge clk); #1; end
    wb_ready = 1;
    send(5'd3, 6'd4, 1'b0);
    idle(4);

    // streaming at one result per cycle
    for (int i = 0; i < 10; i++) send(5'(10 + i), 6'(i + 1), 1'b0);
    idle(3);

    // inconsistent results, then valid ones; err must stay set
    send(5'd20, 6'd0, 1'b0);
    send(5'd21, 6'd40, 1'b0);
    send(5'd22, 6'd3, 1'b1);
    send(5'd23, 6'd33, 1'b0);
    send(5'd24, 6'd0, 1'b1);
    send(5'd25, 6'd31, 1'b0);
    idle(3);

    // reset with a full buffer discards both entries
    wb_ready = 0;
    send(5'd26, 6'd6, 1'b0);
    send(5'd27, 6'd7, 1'b0);
    idle(1);
    do_reset(2);
    wb_ready = 1;
    idle(3);

    // random traffic with random write-port back-pressure
    rand_wb = 1;
    for (int i = 0; i < 60; i++) begin
      send(5'($urandom_range(0, 31)), 6'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_wb = 0;
    wb_ready = 1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/diff_wb_stage.md
# diff_wb_stage

Writeback buffer that consumes the LSB-difference result (`diff`, `eq`) produced by the diff unit in the RISC execute path and delivers it to the register-file write port. It holds up to two results in a skid buffer so execute never stalls on a single-cycle write-port conflict. It also maintains the architectural zero flag, a sticky consistency-error flag and a retired-result counter.

## Interface
- `DATA_W`, 32, register-file write data width; the 6-bit result is zero-extended to this width.
- `RADDR_W`, 5, destination register index width.
- `CNT_W`, 16, width of the retired-result counter.

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `in_valid`  in  1  diff result presented
- `in_ready`  out  1  stage can accept a result this cycle
- `in_diff`  in  6  1-based LSB difference position, 0 when operands are equal
- `in_eq`  in  1  operands equal
- `in_rd`  in  RADDR_W  destination register
- `wb_valid`  out  1  write request to register file
- `wb_ready`  in  1  register file accepts write this cycle
- `wb_rd`  out  RADDR_W  write address
- `wb_data`  out  DATA_W  write data
- `flag_zero`  out  1  eq of most recently retired result
- `err`  out  1  sticky; an inconsistent result was accepted
- `retired`  out  CNT_W  count of retired results, saturating

## Operation
- Storage: 2-entry FIFO. Each entry holds {rd, data, eq}. Occupancy states are EMPTY, ONE and FULL.
- Push: occurs when `in_valid & in_ready`. Pop: occurs when `wb_valid & wb_ready`.
- `in_ready` = state != FULL. It depends only on registered state, with no combinational path from `wb_ready`.
- `wb_valid` = state != EMPTY. `wb_rd`, `wb_data` and the entry's eq always reflect the head entry.
- State transitions:
  - EMPTY: push → ONE; otherwise stay.
  - ONE: push without pop → FULL; pop without push → EMPTY; push with pop → ONE, new entry becomes head.
  - FULL: pop → ONE; push cannot occur.
- Consistency check at push:
  - A result is valid when `in_diff` ≤ 32, and (`in_eq`=1 with `in_diff`=0) or (`in_eq`=0 with `in_diff` in 1..32).
  - A valid result is stored as `data` = zero-extended `in_diff`.
  - An invalid result is stored with `data`=0 and eq=1, and `err` sets on the following edge.
  - `err` clears only on reset.
- On pop:
  - `flag_zero` takes the head entry's eq.
  - `retired` increments by 1 and saturates at 2^CNT_W−1; it never wraps.
- `in_*` inputs are ignored when no push occurs.
- `wb_rd`/`wb_data` are undefined-free: they equal head contents, or 0 when EMPTY.

## Timing
- Reset (`rst`=1 at an edge) forces:
  - state EMPTY, `in_ready`=0 while `rst` is high, `wb_valid`=0, `wb_rd`=0, `wb_data`=0, `flag_zero`=0, `err`=0, `retired`=0.
  - `in_ready` rises in the first cycle after `rst` deasserts.
- Reset mid-operation discards all buffered entries; no write is issued for them.
- Latency: a result pushed at edge N is presented with `wb_valid`=1 from cycle N+1, if the buffer was EMPTY.
- Throughput: 1 result/cycle sustained while `wb_ready`=1.
- With `wb_ready` held low, two results are accepted, then `in_ready` drops. It rises one cycle after the first pop.
- Ordering: strict FIFO; results retire in acceptance order.
- `flag_zero`, `err` and `retired` update on the edge where the corresponding pop or push occurs, and are visible the next cycle.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid`=1 → `in_ready`=0, `wb_valid`=0, all outputs 0; no entry stored after release.
- Single result: push `in_diff`=5, `in_eq`=0, `in_rd`=7, with `wb_ready`=1 → next cycle `wb_valid`=1, `wb_rd`=7, `wb_data`=5; after pop `flag_zero`=0, `retired`=1.
- Back-pressure: `wb_ready`=0, push rd=1 diff=32, then rd=2 diff=0 eq=1, then attempt rd=3 → `in_ready`=0 on the third. Release `wb_ready` → writes (1,32) then (2,0). `flag_zero`=1 after the second; rd=3 is accepted only after `in_ready` returns.
- Simultaneous push/pop in ONE: stream 10 results at 1/cycle with `wb_ready`=1 → 10 writes in order, each one cycle after its push; `retired`=10.
- Inconsistent input: push `in_diff`=0, `in_eq`=0 → `wb_data`=0, `err`=1 and stays 1 across later valid results until `rst`.
- Saturation, with CNT_W overridden to 2: retire 5 results → `retired`=3.
